decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, the pc_out value driven during reset and for bubbles.
REQ-002 The block SHALL have port clock  in  1  sole clock; all state updates on posedge clock.
REQ-003 The block SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port pc_in  in  32  fetched PC from fetch; 32'h0 marks a fetch bubble.
REQ-005 The block SHALL have port insn_in  in  32  instruction word read from instruction memory for pc_in.
REQ-006 The block SHALL have port do_branch  in  1  execute redirect; flushes the instruction in decode.
REQ-007 The block SHALL have ports rs_addr, rt_addr  out  5  register-file read addresses (combinational from current instruction).
REQ-008 The block SHALL have ports rs_data, rt_data  in  32  register-file read data.
REQ-009 The block SHALL have port stall  out  1  load-use hold request to fetch.
REQ-010 The block SHALL have registered ID/EX outputs: pc_out 32, rs_val 32, rt_val 32, imm 32, shamt 5, dest 5, alu_op 4, reg_write 1, mem_read 1, mem_write 1, branch 2 (00 none, 01 BEQ, 10 BNE), jump 2 (00 none, 01 J/JAL, 10 JR), link 1, valid_out 1, illegal 1.

Function
REQ-011 Supported set SHALL be: ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA JR; ADDI ADDIU SLTI SLTIU ANDI ORI XORI LUI LW SW BEQ BNE; J JAL. Any other encoding SHALL be illegal.
REQ-012 The current instruction SHALL be insn_in in state RUN and the held register hold_insn/hold_pc in state REPLAY.
REQ-013 imm SHALL be sign-extended insn[15:0] except ANDI/ORI/XORI (zero-extended), LUI ({insn[15:0],16'h0}), and J/JAL ({pc+4[31:28],insn[25:0],2'b00}).
REQ-014 dest SHALL be rd for R-type, rt for I-type ALU/LW/LUI, 31 for JAL, and 0 with reg_write=0 for SW/BEQ/BNE/J/JR; dest=0 SHALL always force reg_write=0.
REQ-015 Hazard SHALL be asserted when valid_out=1, mem_read=1, dest!=0, and dest equals rs (if the instruction uses rs) or rt (if it uses rt as a source).
REQ-016 FSM states SHALL be RUN and REPLAY; reset enters RUN.
REQ-017 In RUN without hazard, the next edge SHALL load the ID/EX outputs with the decoded instruction and valid_out=1 (latency 1 cycle pc_in -> pc_out).
REQ-018 In RUN with hazard, stall SHALL be 1 combinationally; the next edge SHALL capture insn_in/pc_in into hold_insn/hold_pc, load a bubble, and go to REPLAY.
REQ-019 In REPLAY, stall SHALL be 0; the next edge SHALL decode the held instruction into ID/EX and return to RUN. A second hazard cannot occur here because the ID/EX stage holds a bubble.
REQ-020 A bubble SHALL be: valid_out=0, reg_write=mem_read=mem_write=0, branch=jump=0, link=0, illegal=0, pc_out=RESET_PC, dest=0.
REQ-021 pc_in==32'h0 SHALL be decoded as a bubble, and no hazard SHALL be raised for it.
REQ-022 do_branch=1 SHALL take priority over all else: the next edge loads a bubble, state goes to RUN, hold is discarded, and stall is forced to 0 that cycle.
REQ-023 An illegal instruction SHALL produce a bubble with illegal=1 for exactly one cycle.
REQ-024 insn 32'h0 (SLL $0) SHALL decode as a valid instruction with reg_write=0.

Reset
REQ-025 While reset_n=0, all ID/EX outputs SHALL be at bubble values, state SHALL be RUN, hold registers SHALL be 0, and stall SHALL be 0.
REQ-026 Reset assertion mid-REPLAY SHALL discard the held instruction; the first edge after release SHALL decode insn_in.

Structure
REQ-027 Opcode/funct constants, alu_op encoding, and branch/jump codes SHALL live in shared package mips_pkg, which execute also uses.
REQ-028 Combinational field decode SHALL be the sub-module decode_ctrl (instruction in, control/imm/dest out); decode holds the FSM, hazard logic, and ID/EX registers.

Verification
REQ-029 pc_in=32'h80020000, insn=ADDI $8,$9,-1 (0x2128FFFF) -> next cycle valid_out=1, dest=8, imm=0xFFFFFFFF, reg_write=1.
REQ-030 LW $8,0($9) followed by ADD $10,$8,$11 -> stall=1 for one cycle, one bubble, then ADD issues with the same pc_out.
REQ-031 LW $0 followed by a user of $0 -> no stall.
REQ-032 do_branch=1 in the same cycle as a hazard -> bubble, stall=0, state RUN, held instruction never issued.
REQ-033 JAL 0x0100000 at pc 0x80020000 -> dest=31, link=1, jump=01, imm=0x80400000.
REQ-034 Opcode 0x3F -> illegal=1 for one cycle, valid_out=0; reset_n pulled low during REPLAY -> outputs at bubble values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS encoding constants for the decode and execute
//               stages: opcode and funct values, the ALU operation codes,
//               the branch/jump class codes, the decode FSM state type and
//               the control bundle produced by the field decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes (insn[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_SLTIU = 6'h0B;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type function codes (insn[5:0])
  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_SRA  = 6'h03;
  localparam logic [5:0] c_FN_JR   = 6'h08;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_NOR  = 6'h27;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;
  localparam logic [5:0] c_FN_SLTU = 6'h2B;

  // ALU operation codes consumed by execute
  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_AND  = 4'd2;
  localparam logic [3:0] c_ALU_OR   = 4'd3;
  localparam logic [3:0] c_ALU_XOR  = 4'd4;
  localparam logic [3:0] c_ALU_NOR  = 4'd5;
  localparam logic [3:0] c_ALU_SLT  = 4'd6;
  localparam logic [3:0] c_ALU_SLTU = 4'd7;
  localparam logic [3:0] c_ALU_SLL  = 4'd8;
  localparam logic [3:0] c_ALU_SRL  = 4'd9;
  localparam logic [3:0] c_ALU_SRA  = 4'd10;
  localparam logic [3:0] c_ALU_LUI  = 4'd11;

  // Branch / jump class codes
  localparam logic [1:0] c_BR_NONE  = 2'b00;
  localparam logic [1:0] c_BR_BEQ   = 2'b01;
  localparam logic [1:0] c_BR_BNE   = 2'b10;
  localparam logic [1:0] c_JMP_NONE = 2'b00;
  localparam logic [1:0] c_JMP_J    = 2'b01;
  localparam logic [1:0] c_JMP_JR   = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_REPLAY = 1'b1
  } dec_state_t;

  // Field-decoder result; uses_rs/uses_rt flag source-register reads.
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic        link;
    logic        illegal;
    logic        uses_rs;
    logic        uses_rt;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl
// Description : Purely combinational instruction field decoder.
//   i_insn  in  32  instruction word being decoded
//   i_pc    in  32  PC of that instruction (upper bits of pc+4 form J targets)
//   o_ctrl  out     control bundle: imm, shamt, dest, alu_op, write/mem
//                   enables, branch/jump class, link, illegal, source usage
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl
  import mips_pkg::*;
(
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  output ctrl_t       o_ctrl
);

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_pc4;
  logic [31:0] w_jtarget;
  logic        w_unused_pc4;

  assign w_op      = i_insn[31:26];
  assign w_fn      = i_insn[5:0];
  assign w_rt      = i_insn[20:16];
  assign w_rd      = i_insn[15:11];
  assign w_sext    = {{16{i_insn[15]}}, i_insn[15:0]};
  assign w_zext    = {16'h0, i_insn[15:0]};
  assign w_pc4     = i_pc + 32'd4;
  assign w_jtarget = {w_pc4[31:28], i_insn[25:0], 2'b00};
  // Only the segment bits of pc+4 matter for jump targets.
  assign w_unused_pc4 = ^w_pc4[27:0];

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.imm    = w_sext;
    o_ctrl.shamt  = i_insn[10:6];
    o_ctrl.alu_op = c_ALU_ADD;
    o_ctrl.branch = c_BR_NONE;
    o_ctrl.jump   = c_JMP_NONE;
    case (w_op)
      c_OP_RTYPE: begin
        o_ctrl.dest      = w_rd;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.uses_rs   = 1'b1;
        o_ctrl.uses_rt   = 1'b1;
        case (w_fn)
          c_FN_ADD, c_FN_ADDU: o_ctrl.alu_op = c_ALU_ADD;
          c_FN_SUB, c_FN_SUBU: o_ctrl.alu_op = c_ALU_SUB;
          c_FN_AND:            o_ctrl.alu_op = c_ALU_AND;
          c_FN_OR:             o_ctrl.alu_op = c_ALU_OR;
          c_FN_XOR:            o_ctrl.alu_op = c_ALU_XOR;
          c_FN_NOR:            o_ctrl.alu_op = c_ALU_NOR;
          c_FN_SLT:            o_ctrl.alu_op = c_ALU_SLT;
          c_FN_SLTU:           o_ctrl.alu_op = c_ALU_SLTU;
          // Shifts take their amount from shamt, not from rs.
          c_FN_SLL: begin o_ctrl.alu_op = c_ALU_SLL; o_ctrl.uses_rs = 1'b0; end
          c_FN_SRL: begin o_ctrl.alu_op = c_ALU_SRL; o_ctrl.uses_rs = 1'b0; end
          c_FN_SRA: begin o_ctrl.alu_op = c_ALU_SRA; o_ctrl.uses_rs = 1'b0; end
          c_FN_JR: begin
            o_ctrl.dest      = 5'd0;
            o_ctrl.reg_write = 1'b0;
            o_ctrl.uses_rt   = 1'b0;
            o_ctrl.jump      = c_JMP_JR;
          end
          default: begin
            o_ctrl.illegal   = 1'b1;
            o_ctrl.dest      = 5'd0;
            o_ctrl.reg_write = 1'b0;
            o_ctrl.uses_rs   = 1'b0;
            o_ctrl.uses_rt   = 1'b0;
          end
        endcase
      end
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU: begin
        o_ctrl.dest      = w_rt;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.uses_rs   = 1'b1;
        if (w_op == c_OP_SLTI)       o_ctrl.alu_op = c_ALU_SLT;
        else if (w_op == c_OP_SLTIU) o_ctrl.alu_op = c_ALU_SLTU;
        else                         o_ctrl.alu_op = c_ALU_ADD;
      end
      c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
        o_ctrl.dest      = w_rt;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.uses_rs   = 1'b1;
        o_ctrl.imm       = w_zext;
        if (w_op == c_OP_ANDI)     o_ctrl.alu_op = c_ALU_AND;
        else if (w_op == c_OP_ORI) o_ctrl.alu_op = c_ALU_OR;
        else                       o_ctrl.alu_op = c_ALU_XOR;
      end
      c_OP_LUI: begin
        o_ctrl.dest      = w_rt;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = c_ALU_LUI;
        o_ctrl.imm       = {i_insn[15:0], 16'h0};
      end
      c_OP_LW: begin
        o_ctrl.dest      = w_rt;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.uses_rs   = 1'b1;
      end
      c_OP_SW: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.uses_rs   = 1'b1;
        o_ctrl.uses_rt   = 1'b1;
      end
      c_OP_BEQ, c_OP_BNE: begin
        o_ctrl.alu_op  = c_ALU_SUB;
        o_ctrl.branch  = (w_op == c_OP_BEQ) ? c_BR_BEQ : c_BR_BNE;
        o_ctrl.uses_rs = 1'b1;
        o_ctrl.uses_rt = 1'b1;
      end
      c_OP_J: begin
        o_ctrl.jump = c_JMP_J;
        o_ctrl.imm  = w_jtarget;
      end
      c_OP_JAL: begin
        o_ctrl.jump      = c_JMP_J;
        o_ctrl.imm       = w_jtarget;
        o_ctrl.dest      = 5'd31;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.link      = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
    // Writes to $0 are discarded, so never request them.
    if (o_ctrl.dest == 5'd0) o_ctrl.reg_write = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module      : decode
// Description : MIPS decode stage: load-use hazard detection with a one-deep
//               replay buffer, branch flush, and the ID/EX pipeline register.
//   clock, reset_n        clock / asynchronous active-low reset
//   pc_in, insn_in        fetched PC (0 = fetch bubble) and instruction
//   do_branch             execute redirect, flushes decode
//   rs_addr, rt_addr      register-file read addresses (combinational)
//   rs_data, rt_data      register-file read data
//   stall                 load-use hold request to fetch
//   pc_out .. illegal     registered ID/EX outputs
// Revision    : 1.0 - initial release
// ============================================================================
module decode
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        do_branch,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] imm,
  output logic [4:0]  shamt,
  output logic [4:0]  dest,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  branch,
  output logic [1:0]  jump,
  output logic        link,
  output logic        valid_out,
  output logic        illegal
);

  dec_state_t  r_state;
  dec_state_t  w_state_next;
  logic [31:0] r_hold_insn;
  logic [31:0] r_hold_pc;
  logic [31:0] w_cur_insn;
  logic [31:0] w_cur_pc;
  ctrl_t       w_ctrl;
  logic        w_in_run;
  logic        w_reads_dest;
  logic        w_hazard;
  logic        w_issue;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_cur_insn = w_in_run ? insn_in : r_hold_insn;
  assign w_cur_pc   = w_in_run ? pc_in   : r_hold_pc;

  decode_ctrl u_ctrl (
    .i_insn (w_cur_insn),
    .i_pc   (w_cur_pc),
    .o_ctrl (w_ctrl)
  );

  assign rs_addr = w_cur_insn[25:21];
  assign rt_addr = w_cur_insn[20:16];

  // A load in ID/EX whose result a source operand needs is not yet available.
  assign w_reads_dest = (w_ctrl.uses_rs && (rs_addr == dest)) ||
                        (w_ctrl.uses_rt && (rt_addr == dest));
  assign w_hazard = w_in_run && (w_cur_pc != 32'h0) && valid_out && mem_read &&
                    (dest != 5'd0) && w_reads_dest;
  assign stall    = w_hazard && !do_branch;
  assign w_issue  = !do_branch && !w_hazard && (w_cur_pc != 32'h0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    w_state_next = (w_hazard && !do_branch) ? ST_REPLAY : ST_RUN;
      ST_REPLAY: w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_insn <= 32'h0;
      r_hold_pc   <= 32'h0;
    end else if (do_branch) begin
      r_hold_insn <= 32'h0;
      r_hold_pc   <= 32'h0;
    end else if (w_hazard) begin
      r_hold_insn <= insn_in;
      r_hold_pc   <= pc_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_out    <= RESET_PC;
      rs_val    <= 32'h0;
      rt_val    <= 32'h0;
      imm       <= 32'h0;
      shamt     <= 5'd0;
      dest      <= 5'd0;
      alu_op    <= c_ALU_ADD;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= c_BR_NONE;
      jump      <= c_JMP_NONE;
      link      <= 1'b0;
      valid_out <= 1'b0;
      illegal   <= 1'b0;
    end else if (w_issue && !w_ctrl.illegal) begin
      pc_out    <= w_cur_pc;
      rs_val    <= rs_data;
      rt_val    <= rt_data;
      imm       <= w_ctrl.imm;
      shamt     <= w_ctrl.shamt;
      dest      <= w_ctrl.dest;
      alu_op    <= w_ctrl.alu_op;
      reg_write <= w_ctrl.reg_write;
      mem_read  <= w_ctrl.mem_read;
      mem_write <= w_ctrl.mem_write;
      branch    <= w_ctrl.branch;
      jump      <= w_ctrl.jump;
      link      <= w_ctrl.link;
      valid_out <= 1'b1;
      illegal   <= 1'b0;
    end else begin
      // Bubble; an illegal instruction is flagged on the bubble it becomes.
      pc_out    <= RESET_PC;
      rs_val    <= 32'h0;
      rt_val    <= 32'h0;
      imm       <= 32'h0;
      shamt     <= 5'd0;
      dest      <= 5'd0;
      alu_op    <= c_ALU_ADD;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= c_BR_NONE;
      jump      <= c_JMP_NONE;
      link      <= 1'b0;
      valid_out <= 1'b0;
      illegal   <= w_issue && w_ctrl.illegal;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode
// Description : Self-checking bench for decode. A mnemonic-level reference
//               model predicts stall, read addresses and the ID/EX outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode;
  import mips_pkg::*;

  localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in, insn_in, rs_data, rt_data;
  logic        do_branch, stall;
  logic [4:0]  rs_addr, rt_addr, shamt, dest;
  logic [31:0] pc_out, rs_val, rt_val, imm;
  logic [3:0]  alu_op;
  logic        reg_write, mem_read, mem_write, link, valid_out, illegal;
  logic [1:0]  branch, jump;

  always #5 clock = ~clock;

  logic [31:0] regs [32];
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  decode #(.RESET_PC(c_RESET_PC)) dut (
    .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .insn_in(insn_in),
    .do_branch(do_branch), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .pc_out(pc_out),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .shamt(shamt), .dest(dest),
    .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .link(link),
    .valid_out(valid_out), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc, rsv, rtv, imm;
    logic [4:0]  shamt, dest;
    logic [3:0]  alu;
    logic        rw, mr, mw;
    logic [1:0]  br, jp;
    logic        lk, vld, ill;
  } idex_t;

  idex_t obs;
  assign obs = {pc_out, rs_val, rt_val, imm, shamt, dest, alu_op, reg_write,
                mem_read, mem_write, branch, jump, link, valid_out, illegal};

  typedef enum int {
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SRA, M_JR, M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI,
    M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_ILL
  } mn_t;

  // MIPS-I opcode / funct per mnemonic, in mn_t order.
  localparam logic [5:0] c_OP_TAB [28] = '{
    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
    6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  localparam logic [5:0] c_FN_TAB [28] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
    6'h00, 6'h02, 6'h03, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: expected ID/EX contents and the instruction parked by a stall.
  idex_t       m_out;
  logic        m_held;
  logic [31:0] m_hinsn, m_hpc;

  function automatic mn_t classify(input logic [31:0] insn);
    mn_t r = M_ILL;
    for (int k = 0; k < 28; k++)
      if (insn[31:26] == c_OP_TAB[k] && (c_OP_TAB[k] != 6'h00 || insn[5:0] == c_FN_TAB[k]))
        r = mn_t'(k);
    return r;
  endfunction

  function automatic logic reads_reg(input logic [31:0] insn, input logic [4:0] r);
    mn_t m = classify(insn);
    logic use_rs = !(m inside {M_SLL, M_SRL, M_SRA, M_LUI, M_J, M_JAL, M_ILL});
    logic use_rt = (m <= M_SRA) || (m inside {M_SW, M_BEQ, M_BNE});
    return (use_rs && insn[25:21] == r) || (use_rt && insn[20:16] == r);
  endfunction

  function automatic idex_t bubble(input logic ill);
    idex_t e = '0;
    e.pc  = c_RESET_PC;
    e.ill = ill;
    return e;
  endfunction

  function automatic idex_t ref_issue(input logic [31:0] insn, input logic [31:0] pc);
    mn_t m = classify(insn);
    idex_t e;
    logic [31:0] pc4 = pc + 32'd4;
    if (pc == 32'h0) return bubble(1'b0);
    if (m == M_ILL)  return bubble(1'b1);
    e = '0;
    e.pc = pc; e.vld = 1'b1;
    e.rsv = regs[insn[25:21]]; e.rtv = regs[insn[20:16]];
    e.shamt = insn[10:6];
    if (m inside {M_ANDI, M_ORI, M_XORI}) e.imm = {16'h0, insn[15:0]};
    else if (m == M_LUI)                  e.imm = {insn[15:0], 16'h0};
    else if (m inside {M_J, M_JAL})       e.imm = {pc4[31:28], insn[25:0], 2'b00};
    else                                  e.imm = {{16{insn[15]}}, insn[15:0]};
    case (m)
      M_SUB, M_SUBU, M_BEQ, M_BNE: e.alu = c_ALU_SUB;
      M_AND, M_ANDI:               e.alu = c_ALU_AND;
      M_OR, M_ORI:                 e.alu = c_ALU_OR;
      M_XOR, M_XORI:               e.alu = c_ALU_XOR;
      M_NOR:                       e.alu = c_ALU_NOR;
      M_SLT, M_SLTI:               e.alu = c_ALU_SLT;
      M_SLTU, M_SLTIU:             e.alu = c_ALU_SLTU;
      M_SLL:                       e.alu = c_ALU_SLL;
      M_SRL:                       e.alu = c_ALU_SRL;
      M_SRA:                       e.alu = c_ALU_SRA;
      M_LUI:                       e.alu = c_ALU_LUI;
      default:                     e.alu = c_ALU_ADD;
    endcase
    if (m <= M_SRA)                     e.dest = insn[15:11];
    else if (m >= M_ADDI && m <= M_LW)  e.dest = insn[20:16];
    else if (m == M_JAL)                e.dest = 5'd31;
    else                                e.dest = 5'd0;
    e.rw = (e.dest != 5'd0);
    e.mr = (m == M_LW);
    e.mw = (m == M_SW);
    e.br = (m == M_BEQ) ? 2'b01 : (m == M_BNE) ? 2'b10 : 2'b00;
    e.jp = (m inside {M_J, M_JAL}) ? 2'b01 : (m == M_JR) ? 2'b10 : 2'b00;
    e.lk = (m == M_JAL);
    return e;
  endfunction

  // Drives one fetch cycle from posedge+1, samples stall/addresses mid-cycle,
  // advances the model across the edge and returns at the next posedge+1.
  task automatic step(input logic [31:0] pc, input logic [31:0] insn, input logic br,
                      output logic got_stall, output logic exp_stall,
                      output logic [9:0] got_addr, output logic [9:0] exp_addr);
    logic [31:0] ci, cp;
    logic haz;
    pc_in = pc; insn_in = insn; do_branch = br;
    ci = m_held ? m_hinsn : insn;
    cp = m_held ? m_hpc : pc;
    haz = !m_held && cp != 32'h0 && m_out.vld && m_out.mr && m_out.dest != 5'd0 &&
          reads_reg(ci, m_out.dest);
    exp_stall = haz && !br;
    exp_addr  = ci[25:16];
    @(negedge clock);
    got_stall = stall;
    got_addr  = {rs_addr, rt_addr};
    if (br)       begin m_out = bubble(1'b0); m_held = 1'b0; end
    else if (haz) begin m_out = bubble(1'b0); m_held = 1'b1; m_hinsn = insn; m_hpc = pc; end
    else          begin m_out = ref_issue(ci, cp); m_held = 1'b0; end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; do_branch = 1'b0;
    pc_in = 32'h8002_0000; insn_in = 32'h010B_5020;
    m_out = bubble(1'b0); m_held = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      n_cmp++;
      if (obs !== m_out) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, m_out); end
      n_cmp++;
      if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_addi();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h8002_0000, 32'h2128_FFFF, 1'b0, gs, es, ga, ea);
    n_cmp++;
    if (obs !== m_out) begin n_bad++; $display("FAIL addi_model: got %h want %h", obs, m_out); end
    n_cmp++;
    if ({valid_out, dest, imm, reg_write} !== {1'b1, 5'd8, 32'hFFFF_FFFF, 1'b1}) begin
      n_bad++; $display("FAIL addi_fields: got v=%b d=%0d imm=%h rw=%b want v=1 d=8 imm=ffffffff rw=1",
                        valid_out, dest, imm, reg_write);
    end
  endtask

  task automatic test_load_use();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h0040_0000, 32'h8D28_0000, 1'b0, gs, es, ga, ea);   // LW $8,0($9)
    step(32'h0040_0004, 32'h010B_5020, 1'b0, gs, es, ga, ea);   // ADD $10,$8,$11
    n_cmp++;
    if (gs !== 1'b1 || es !== 1'b1) begin n_bad++; $display("FAIL loaduse_stall: got %b want 1", gs); end
    n_cmp++;
    if (obs !== m_out || valid_out !== 1'b0) begin n_bad++; $display("FAIL loaduse_bubble: got %h want %h", obs, m_out); end
    step(32'h0040_0008, 32'h34C5_1234, 1'b0, gs, es, ga, ea);   // replay cycle
    n_cmp++;
    if (gs !== 1'b0) begin n_bad++; $display("FAIL replay_stall: got %b want 0", gs); end
    n_cmp++;
    if (pc_out !== 32'h0040_0004 || valid_out !== 1'b1 || dest !== 5'd10) begin
      n_bad++; $display("FAIL replay_issue: got pc=%h v=%b d=%0d want pc=00400004 v=1 d=10", pc_out, valid_out, dest);
    end
    n_cmp++;
    if (obs !== m_out) begin n_bad++; $display("FAIL replay_model: got %h want %h", obs, m_out); end
    step(32'h0040_0008, 32'h34C5_1234, 1'b0, gs, es, ga, ea);
    n_cmp++;
    if (obs !== m_out || gs !== es) begin n_bad++; $display("FAIL after_replay: got %h want %h", obs, m_out); end
  endtask

  task automatic test_load_zero();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h0040_0100, 32'h8D20_0000, 1'b0, gs, es, ga, ea);   // LW $0,0($9)
    step(32'h0040_0104, 32'h0000_5020, 1'b0, gs, es, ga, ea);   // ADD $10,$0,$0
    n_cmp++;
    if (gs !== 1'b0) begin n_bad++; $display("FAIL lw0_stall: got %b want 0", gs); end
    n_cmp++;
    if (obs !== m_out || pc_out !== 32'h0040_0104) begin n_bad++; $display("FAIL lw0_issue: got %h want %h", obs, m_out); end
  endtask

  task automatic test_branch_hazard();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h0040_0200, 32'h8D28_0000, 1'b0, gs, es, ga, ea);
    step(32'h0040_0204, 32'h010B_5020, 1'b1, gs, es, ga, ea);   // hazard + redirect
    n_cmp++;
    if (gs !== 1'b0) begin n_bad++; $display("FAIL brhaz_stall: got %b want 0", gs); end
    n_cmp++;
    if (obs !== bubble(1'b0)) begin n_bad++; $display("FAIL brhaz_bubble: got %h want %h", obs, bubble(1'b0)); end
    step(32'h0050_0000, 32'h34C5_1234, 1'b0, gs, es, ga, ea);
    n_cmp++;
    if (pc_out !== 32'h0050_0000 || gs !== 1'b0 || ga !== 10'({5'd6, 5'd5})) begin
      n_bad++; $display("FAIL brhaz_target: got pc=%h stall=%b addr=%h want pc=00500000 stall=0 addr=%h",
                        pc_out, gs, ga, 10'({5'd6, 5'd5}));
    end
  endtask

  task automatic test_jal();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h8002_0000, 32'h0C10_0000, 1'b0, gs, es, ga, ea);
    n_cmp++;
    if ({dest, link, jump, imm, reg_write} !== {5'd31, 1'b1, 2'b01, 32'h8040_0000, 1'b1}) begin
      n_bad++; $display("FAIL jal_fields: got d=%0d lk=%b jp=%b imm=%h want d=31 lk=1 jp=01 imm=80400000",
                        dest, link, jump, imm);
    end
    n_cmp++;
    if (obs !== m_out) begin n_bad++; $display("FAIL jal_model: got %h want %h", obs, m_out); end
  endtask

  task automatic test_illegal();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h0040_0300, 32'hFC00_1234, 1'b0, gs, es, ga, ea);
    n_cmp++;
    if (illegal !== 1'b1 || valid_out !== 1'b0 || pc_out !== c_RESET_PC) begin
      n_bad++; $display("FAIL illegal_set: got ill=%b v=%b pc=%h want ill=1 v=0 pc=%h", illegal, valid_out, pc_out, c_RESET_PC);
    end
    step(32'h0040_0304, 32'h0000_0000, 1'b0, gs, es, ga, ea);   // SLL $0
    n_cmp++;
    if (illegal !== 1'b0 || valid_out !== 1'b1 || reg_write !== 1'b0) begin
      n_bad++; $display("FAIL sll0_after_illegal: got ill=%b v=%b rw=%b want ill=0 v=1 rw=0", illegal, valid_out, reg_write);
    end
    step(32'h0000_0000, 32'h2128_FFFF, 1'b0, gs, es, ga, ea);   // fetch bubble
    n_cmp++;
    if (obs !== bubble(1'b0)) begin n_bad++; $display("FAIL pc0_bubble: got %h want %h", obs, bubble(1'b0)); end
  endtask

  task automatic test_reset_replay();
    logic gs, es; logic [9:0] ga, ea;
    step(32'h0040_0400, 32'h8D28_0000, 1'b0, gs, es, ga, ea);
    step(32'h0040_0404, 32'h010B_5020, 1'b0, gs, es, ga, ea);   // now replaying
    reset_n = 1'b0;
    #1;
    m_out = bubble(1'b0); m_held = 1'b0;
    n_cmp++;
    if (obs !== m_out || stall !== 1'b0) begin n_bad++; $display("FAIL rst_replay_now: got %h stall=%b want %h stall=0", obs, stall, m_out); end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(32'h0040_0100, 32'h34C5_1234, 1'b0, gs, es, ga, ea);
    n_cmp++;
    if (pc_out !== 32'h0040_0100 || valid_out !== 1'b1 || obs !== m_out) begin
      n_bad++; $display("FAIL rst_replay_first: got %h want %h", obs, m_out);
    end
  endtask

  task automatic test_random();
    logic gs, es; logic [9:0] ga, ea;
    logic [31:0] pcr, rnd, insn, pc;
    logic [4:0] rs, rt, rd;
    int k;
    for (int n = 0; n < 400; n++) begin
      k   = $urandom_range(0, 28);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      rnd = $urandom;
      pcr = $urandom;
      if (k == 28) begin
        case ($urandom_range(0, 2))
          0:       insn = {6'h3F, rnd[25:0]};
          1:       insn = {6'h01, rnd[25:0]};
          default: insn = {6'h00, rnd[25:6], 6'h01};
        endcase
      end else if (c_OP_TAB[k] == 6'h00) insn = {6'h00, rs, rt, rd, rnd[4:0], c_FN_TAB[k]};
      else if (k >= 26)                  insn = {c_OP_TAB[k], rnd[25:0]};
      else                               insn = {c_OP_TAB[k], rs, rt, rnd[15:0]};
      pc = ($urandom_range(0, 9) == 0) ? 32'h0 : ({pcr[31:2], 2'b00} | 32'h4);
      step(pc, insn, ($urandom_range(0, 11) == 0), gs, es, ga, ea);
      n_cmp++;
      if (gs !== es) begin n_bad++; $display("FAIL rand_stall[%0d]: got %b want %b", n, gs, es); end
      n_cmp++;
      if (ga !== ea) begin n_bad++; $display("FAIL rand_addr[%0d]: got %h want %h", n, ga, ea); end
      n_cmp++;
      if (obs !== m_out) begin n_bad++; $display("FAIL rand_idex[%0d]: got %h want %h", n, obs, m_out); end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    reset_n = 1'b0; pc_in = 32'h0; insn_in = 32'h0; do_branch = 1'b0;
    m_out = bubble(1'b0); m_held = 1'b0; m_hinsn = 32'h0; m_hpc = 32'h0;
    test_reset();
    test_addi();
    test_load_use();
    test_load_zero();
    test_branch_hazard();
    test_jal();
    test_illegal();
    test_reset_replay();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
